// File: rtl/input_debouncer_if.sv
// Signal bundle between raw board inputs and the debounced level/edge outputs.
// The master drives raw levels; the debouncer (slave) returns clean levels and pulses.
interface input_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] stable_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output raw_in,
    input  stable_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  raw_in,
    output stable_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/input_debouncer.sv
// Per-channel two-flop synchroniser followed by a stability counter that only accepts
// a new level after it persists DEBOUNCE_CYCLES cycles; emits registered edge pulses.
module input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input_debouncer_if.slave bus
);
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] stable_bits;
  logic [WIDTH-1:0] rise_bits;
  logic [WIDTH-1:0] fall_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= bus.raw_in;
      s2_reg <= s1_reg;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [CNT_W-1:0] cnt_reg;
    logic             stable_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             mismatch;
    logic             accept;

    // Acceptance happens on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
    assign mismatch = s2_reg[gi] ^ stable_reg;
    assign accept   = mismatch && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg    <= '0;
        stable_reg <= 1'b0;
        rise_reg   <= 1'b0;
        fall_reg   <= 1'b0;
      end else begin
        rise_reg <= accept &&  s2_reg[gi];
        fall_reg <= accept && !s2_reg[gi];
        if (!mismatch || accept) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (accept) begin
          stable_reg <= s2_reg[gi];
        end
      end
    end

    assign stable_bits[gi] = stable_reg;
    assign rise_bits[gi]   = rise_reg;
    assign fall_bits[gi]   = fall_reg;
  end

  assign bus.stable_out = stable_bits;
  assign bus.rise_pulse = rise_bits;
  assign bus.fall_pulse = fall_bits;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed vector table and reset corner cases at DEBOUNCE_CYCLES=4, then a seeded
// random-bounce run at DEBOUNCE_CYCLES=16 against a sliding-window reference model.
module tb_input_debouncer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_debouncer_if #(.WIDTH(W)) b4 ();
  input_debouncer_if #(.WIDTH(W)) b16 ();

  input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] st;
    logic [3:0] ri;
    logic [3:0] fa;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passed = 0;

  task automatic put(input int n, input logic [3:0] raw, input logic [3:0] st,
                     input logic [3:0] ri, input logic [3:0] fa);
    vec_t v;
    v.raw = raw;
    v.st  = st;
    v.ri  = ri;
    v.fa  = fa;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk4(input string name, input logic [3:0] st, input logic [3:0] ri,
                      input logic [3:0] fa);
    chk({name, "_stable"}, b4.stable_out, st);
    chk({name, "_rise"},   b4.rise_pulse, ri);
    chk({name, "_fall"},   b4.fall_pulse, fa);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    a_excl4: assert ((b4.rise_pulse & b4.fall_pulse) == '0)
      else $error("FAIL excl4 rise=%b fall=%b", b4.rise_pulse, b4.fall_pulse);
    a_excl16: assert ((b16.rise_pulse & b16.fall_pulse) == '0)
      else $error("FAIL excl16 rise=%b fall=%b", b16.rise_pulse, b16.fall_pulse);
  end

  logic [3:0]  raw_r;
  logic [3:0]  m_s1, m_s2, m_st, e_ri, e_fa, prev_st;
  logic [15:0] win [4];
  logic        acc;
  int          p;

  initial begin
    b4.raw_in  = '0;
    b16.raw_in = '0;
    rst        = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk4($sformatf("reset%0d", i), 4'b0000, 4'b0000, 4'b0000);
      $display("reset cycle %0d stable=%b", i, b4.stable_out);
    end

    // Record i is driven before relative edge i and checked just after it.
    put(5, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    put(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    put(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    put(3, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    put(3, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    put(3, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    put(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    put(3, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    put(7, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    put(5, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    put(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    put(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    put(5, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
    put(1, 4'b1010, 4'b1010, 4'b1010, 4'b0000);
    put(2, 4'b1010, 4'b1010, 4'b0000, 4'b0000);

    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      b4.raw_in = tbl[i].raw;
      tick();
      chk4($sformatf("vec%0d", i), tbl[i].st, tbl[i].ri, tbl[i].fa);
      $display("vec %0d raw=%b stable=%b rise=%b fall=%b", i, tbl[i].raw,
               b4.stable_out, b4.rise_pulse, b4.fall_pulse);
    end

    // Reset forces stable low with no fall pulse.
    rst = 1'b1;
    b4.raw_in = 4'b0000;
    tick();
    chk4("rst_clear", 4'b0000, 4'b0000, 4'b0000);
    $display("rst_clear stable=%b", b4.stable_out);

    // Channel 2 counts to 2, then reset discards the partial count.
    rst = 1'b0;
    b4.raw_in = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk4($sformatf("midcnt%0d", k), 4'b0000, 4'b0000, 4'b0000);
      $display("midcnt %0d stable=%b", k, b4.stable_out);
    end
    rst = 1'b1;
    tick();
    chk4("midcnt_rst", 4'b0000, 4'b0000, 4'b0000);
    $display("midcnt_rst stable=%b", b4.stable_out);

    // Held-high input would be accepted on the 6th edge after release; reset it there.
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk4($sformatf("pre_acc%0d", k), 4'b0000, 4'b0000, 4'b0000);
      $display("pre_acc %0d stable=%b", k, b4.stable_out);
    end
    rst = 1'b1;
    tick();
    chk4("rst_at_accept", 4'b0000, 4'b0000, 4'b0000);
    $display("rst_at_accept stable=%b rise=%b", b4.stable_out, b4.rise_pulse);

    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk4($sformatf("post_rst%0d", k), (k >= 6) ? 4'b0100 : 4'b0000,
           (k == 6) ? 4'b0100 : 4'b0000, 4'b0000);
      $display("post_rst %0d stable=%b rise=%b", k, b4.stable_out, b4.rise_pulse);
    end

    // Random bounce on the DEBOUNCE_CYCLES=16 instance.
    void'($urandom(32'd20240611));
    rst = 1'b1;
    b16.raw_in = '0;
    tick();
    rst = 1'b0;
    raw_r = '0;
    m_s1 = '0;
    m_s2 = '0;
    m_st = '0;
    for (int c = 0; c < 4; c++) win[c] = '0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      p = ((cyc / 100) % 2 == 0) ? 25 : 1;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(99, 0) < p) raw_r[c] = ~raw_r[c];
      end
      b16.raw_in = raw_r;
      prev_st = b16.stable_out;
      tick();
      for (int c = 0; c < 4; c++) begin
        win[c] = {win[c][14:0], m_s2[c]};
        acc = (win[c] == (m_st[c] ? 16'h0000 : 16'hFFFF));
        e_ri[c] = acc && !m_st[c];
        e_fa[c] = acc &&  m_st[c];
        if (acc) m_st[c] = ~m_st[c];
      end
      m_s2 = m_s1;
      m_s1 = raw_r;
      chk($sformatf("rnd%0d_stable", cyc), b16.stable_out, m_st);
      chk($sformatf("rnd%0d_rise", cyc),   b16.rise_pulse, e_ri);
      chk($sformatf("rnd%0d_fall", cyc),   b16.fall_pulse, e_fa);
      chk($sformatf("rnd%0d_pulse_vs_edge", cyc),
          b16.rise_pulse | b16.fall_pulse, b16.stable_out ^ prev_st);
      $display("rnd %0d raw=%b stable=%b rise=%b fall=%b", cyc, raw_r,
               b16.stable_out, b16.rise_pulse, b16.fall_pulse);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions raw board switch/button inputs before they reach the combinational logic stages. Each channel is synchronised into the clock domain and debounced by a per-channel stability counter. Each channel then drives a clean level plus single-cycle rise/fall pulses. Its stable_out bus directly drives the logic-gate stage inputs.

Parameters:
WIDTH, 4, number of independent input channels (>=1)
DEBOUNCE_CYCLES, 1000000, consecutive cycles a new level must persist before acceptance (10 ms at 100 MHz); must be >=2
CNT_W, $clog2(DEBOUNCE_CYCLES), counter width (derived localparam, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
raw_in  input  WIDTH  asynchronous raw switch/button levels
stable_out  output  WIDTH  debounced level per channel
rise_pulse  output  WIDTH  one-cycle pulse when stable_out[i] goes 0->1
fall_pulse  output  WIDTH  one-cycle pulse when stable_out[i] goes 1->0

Behaviour:
- One clock; reset is synchronous and active-high. rst sampled high at a clock edge clears every register; no asynchronous paths.
- Reset values: sync flops 0, counters 0, stable_out 0, rise_pulse 0, fall_pulse 0.
- Synchroniser: per channel, two flops (s1 <= raw_in, s2 <= s1). Only s2 is used downstream. No logic between the two flops.
- Channels are fully independent. Simultaneous transitions on several channels are each handled on their own schedule.
- Per-channel counter (CNT_W bits):
  - s2[i] == stable_out[i]: counter <= 0.
  - s2[i] != stable_out[i] and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2[i] != stable_out[i] and counter == DEBOUNCE_CYCLES-1: stable_out[i] <= s2[i], counter <= 0.
- Latency: a level held on raw_in and first sampled at edge N appears on stable_out after edge N+DEBOUNCE_CYCLES+1. That is 2 synchroniser edges plus DEBOUNCE_CYCLES mismatch cycles, minus the overlap.
- Glitch rejection: a level held fewer than DEBOUNCE_CYCLES consecutive cycles at s2 never changes stable_out. Any return to the stable level clears the counter, so partial counts never accumulate across glitches.
- Pulses are registered and asserted on the same edge stable_out[i] changes. Each is high for exactly one cycle. rise and fall are never high together on one channel.
- Back-to-back transitions: the minimum spacing between accepted transitions on a channel is DEBOUNCE_CYCLES cycles. Pulses cannot merge.
- Counter never wraps; the maximum reached value is DEBOUNCE_CYCLES-1.
- Reset mid-count: the count is discarded and stable_out is forced to 0.
- Input held high through reset: after rst deasserts it is treated as a new transition. stable_out rises after DEBOUNCE_CYCLES+2 edges (measured from the first non-reset edge), with a rise_pulse.
- rst asserted on the edge a transition would be accepted: reset wins; no pulse.

Test Plan:
- DEBOUNCE_CYCLES=4, WIDTH=4. rst high 3 cycles -> all outputs 0. raw_in=4'b0001 first sampled at edge 10 -> stable_out[0]=1 and rise_pulse[0]=1 after edge 15; rise_pulse[0]=0 after edge 16.
- Glitch: raw_in[1] high for 3 cycles then low -> stable_out[1] stays 0; no pulses. A 3-cycle high, 1-cycle low, 3-cycle high sequence also produces no change.
- Release: from stable_out[0]=1, raw_in[0]=0 sampled at edge 30 -> stable_out[0]=0 and fall_pulse[0]=1 after edge 35, one cycle only.
- Simultaneous: raw_in 4'b0000->4'b1010 at one edge -> channels 3 and 1 rise on the same edge with rise_pulse=4'b1010. Channels 0 and 2 are untouched.
- Reset mid-count: raw_in[2]=1 and rst pulsed at count 2 -> counter cleared. stable_out[2] rises DEBOUNCE_CYCLES+2 edges after rst deasserts, with a single rise_pulse.
- Random bounce (seeded, 2000 cycles, default parameters reduced to 16) -> scoreboard model matches stable_out, rise_pulse and fall_pulse every cycle. Assertions: no simultaneous rise/fall on a channel, and no pulse without a stable_out change.
